// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown scheduler.
package countdown_pkg;

    // Default sizing; the top exposes these as overridable parameters.
    localparam int unsigned DefNumReq = 4;
    localparam int unsigned DefCntW   = 4;

    // Job sequencing states.
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHalve,
        StRun,
        StDone
    } state_e;

    // Round-robin pointer value that places the given owner last in priority.
    function automatic int unsigned next_rr(input int unsigned owner,
                                            input int unsigned num_req);
        int unsigned nxt;
        nxt = owner + 32'd1;
        if (nxt >= num_req) begin
            nxt = 32'd0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// the pointer, wrapping around modulo NUM_REQ.
module rr_arbiter
    import countdown_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               any_o
);

    // Scan candidates in priority order starting at the pointer; first hit wins.
    always_comb begin
        int unsigned cand;
        logic [IDX_W-1:0] cand_idx;
        win_o     = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        cand      = 32'd0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o           = 1'b1;
                win_idx_o       = cand_idx;
                win_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_scheduler.sv
// Shares one loadable down-counter between NUM_REQ requesters. A granted job
// loads its start value, optionally halves it once, counts down to zero and
// then pulses done to its owner. All outputs come straight from registers.
module countdown_scheduler
    import countdown_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*CNT_W-1:0] req_val_i,
    input  logic [NUM_REQ-1:0]       req_half_i,
    input  logic                     abort_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     busy_o,
    output logic [IDX_W-1:0]         owner_o,
    output logic [CNT_W-1:0]         cnt_val_o,
    output logic                     zero_o
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     val_q, val_d;
    logic                 half_q, half_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 zero_q, zero_d;

    logic [NUM_REQ-1:0]   win;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;
    logic [CNT_W-1:0]     sel_val;
    logic                 sel_half;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .win_o     (win),
        .win_idx_o (win_idx),
        .any_o     (win_any)
    );

    // Pick the winner's start value and halve flag out of the packed inputs.
    always_comb begin
        sel_val  = '0;
        sel_half = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                sel_val  = req_val_i[i*CNT_W +: CNT_W];
                sel_half = req_half_i[i];
            end
        end
    end

    // Next-state logic; gnt/done are set on entry to LOAD/DONE so the registered
    // pulse coincides with the state it belongs to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        val_d   = val_q;
        half_d  = half_q;
        gnt_d   = '0;
        done_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (win_any) begin
                    owner_d = win_idx;
                    val_d   = sel_val;
                    half_d  = sel_half;
                    gnt_d   = win;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = val_q;
                state_d = half_q ? StHalve : StRun;
            end
            StHalve: begin
                cnt_d   = cnt_q >> 1;
                state_d = StRun;
            end
            StRun: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    done_d[owner_q] = 1'b1;
                    state_d         = StDone;
                end
            end
            StDone: begin
                ptr_d   = IDX_W'(next_rr(32'(owner_q), NUM_REQ));
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything: counter freezes, no done, owner still
        // loses its turn.
        if (abort_i && (state_q != StIdle)) begin
            state_d = StIdle;
            cnt_d   = cnt_q;
            done_d  = '0;
            ptr_d   = IDX_W'(next_rr(32'(owner_q), NUM_REQ));
        end

        busy_d = (state_d != StIdle);
        zero_d = (cnt_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            val_q   <= '0;
            half_q  <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            val_q   <= val_d;
            half_q  <= half_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            zero_q  <= zero_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign busy_o    = busy_q;
    assign owner_o   = owner_q;
    assign cnt_val_o = cnt_q;
    assign zero_o    = zero_q;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Scoreboard bench for countdown_scheduler: a job-level timing model predicts
// grant/done events and per-cycle counter/busy/owner values.
module tb_countdown_scheduler;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk;
    logic           nrst;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] req_val_i;
    logic [N-1:0]   req_half_i;
    logic           abort_i;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   done_o;
    logic           busy_o;
    logic [1:0]     owner_o;
    logic [W-1:0]   cnt_val_o;
    logic           zero_o;

    countdown_scheduler #(
        .NUM_REQ (N),
        .CNT_W   (W)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_i      (req_i),
        .req_val_i  (req_val_i),
        .req_half_i (req_half_i),
        .abort_i    (abort_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .owner_o    (owner_o),
        .cnt_val_o  (cnt_val_o),
        .zero_o     (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;  // 0 = grant, 1 = done
        int idx;
        int cyc;
    } evt_t;

    evt_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 0;

    // Job record of the model (most recent job).
    bit m_job;
    int m_ptr, m_owner, m_prev_owner;
    int m_load_c, m_end_c, m_done_c;
    int m_v, m_h, m_veff, m_pre;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    // Counter value shown in cycle n, derived from the job's timeline.
    function automatic int exp_cnt(input int n);
        int k, d, r;
        k = (n > m_end_c) ? m_end_c : n;
        if (k <= m_load_c) return m_pre;
        if (m_h != 0 && k == m_load_c + 1) return m_v;
        d = k - (m_load_c + 1 + m_h);
        r = m_veff - d;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic int exp_busy(input int n);
        return (n >= m_load_c && n <= m_end_c) ? 1 : 0;
    endfunction

    function automatic int exp_owner(input int n);
        return (n >= m_load_c) ? m_owner : m_prev_owner;
    endfunction

    task automatic model_reset();
        m_job        = 0;
        m_ptr        = 0;
        m_owner      = 0;
        m_prev_owner = 0;
        m_load_c     = 1 << 30;
        m_end_c      = -1;
        m_done_c     = -1;
        m_v          = 0;
        m_h          = 0;
        m_veff       = 0;
        m_pre        = 0;
        exp_q.delete();
    endtask

    // Apply this cycle's inputs to the model.
    task automatic model_step(input int n);
        int w;
        w = -1;
        if (m_job) begin
            if (abort_i && n < m_done_c) begin
                m_end_c = n;
            end else if (n == m_done_c - 1) begin
                exp_q.push_back('{1, m_owner, m_done_c});
            end
            if (n == m_end_c) begin
                m_job = 0;
                m_ptr = (m_owner + 1) % N;
            end
        end else if (req_i != '0) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req_i[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            m_pre        = exp_cnt(n);
            m_prev_owner = m_owner;
            m_owner      = w;
            m_v          = int'(req_val_i[w*W +: W]);
            m_h          = int'(req_half_i[w]);
            m_veff       = (m_h != 0) ? m_v / 2 : m_v;
            m_load_c     = n + 1;
            m_done_c     = n + 3 + m_veff + m_h;
            m_end_c      = m_done_c;
            m_job        = 1;
            exp_q.push_back('{0, w, n + 1});
        end
    endtask

    task automatic tick(input logic rst_n, input logic [N-1:0] r, input logic [N*W-1:0] v,
                        input logic [N-1:0] h, input logic a);
        @(posedge clk);
        cyc++;
        #1;
        nrst       = rst_n;
        req_i      = r;
        req_val_i  = v;
        req_half_i = h;
        abort_i    = a;
        if (!rst_n) model_reset();
        else model_step(cyc);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick(1'b1, '0, $urandom, '0, 1'b0);
    endtask

    task automatic run_job(input int idx, input int val, input bit half);
        logic [N*W-1:0] v;
        logic [N-1:0]   r, h;
        v = N*W'($urandom);
        v[idx*W +: W] = W'(val);
        r = '0;
        r[idx] = 1'b1;
        h = N'($urandom);
        h[idx] = half;
        tick(1'b1, r, v, h, 1'b0);
        tick(1'b1, r, v, h, 1'b0);
    endtask

    // Idle until the counter for the coming cycle equals target in RUN, then abort.
    task automatic abort_at(input int target);
        int found;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            if (m_job && (cyc + 1) > m_load_c + m_h && (cyc + 1) < m_done_c
                && exp_cnt(cyc + 1) == target) begin
                tick(1'b1, '0, '0, '0, 1'b1);
                found = 1;
            end else begin
                tick(1'b1, '0, '0, '0, 1'b0);
            end
        end
        chk("abort_window_reached", found, 1);
    endtask

    // Monitor: per-cycle value checks and event scoreboard.
    evt_t mon_e;
    int   mon_n;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_n = cyc;
            while (exp_q.size() > 0 && exp_q[0].cyc < mon_n) begin
                mon_e = exp_q.pop_front();
                chk(mon_e.kind == 0 ? "gnt_missing" : "done_missing", 0, 1);
            end
            if (gnt_o != '0 && done_o != '0) chk("gnt_done_exclusive", 1, 0);
            if (gnt_o != '0 || done_o != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", int'({gnt_o, done_o}), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", (gnt_o != '0) ? 0 : 1, mon_e.kind);
                    chk("event_vec", int'((gnt_o != '0) ? gnt_o : done_o), 1 << mon_e.idx);
                    chk("event_cycle", mon_n, mon_e.cyc);
                end
            end
            chk("cnt_val", int'(cnt_val_o), exp_cnt(mon_n));
            chk("zero", int'(zero_o), (exp_cnt(mon_n) == 0) ? 1 : 0);
            chk("busy", int'(busy_o), exp_busy(mon_n));
            chk("owner", int'(owner_o), exp_owner(mon_n));
        end
    end

    initial begin
        logic [N-1:0] rr;
        nrst       = 1'b1;
        req_i      = '0;
        req_val_i  = '0;
        req_half_i = '0;
        abort_i    = 1'b0;
        #2;
        nrst = 1'b0;
        model_reset();
        mon_en = 1;
        tick(1'b0, '0, '0, '0, 1'b0);
        tick(1'b0, '0, '0, '0, 1'b0);
        idle(2);

        // Single jobs: plain, halved, and boundary start values.
        run_job(2, 6, 1'b0);
        idle(12);
        run_job(1, 13, 1'b1);
        idle(12);
        run_job(0, 0, 1'b0);
        idle(6);
        run_job(3, 15, 1'b0);
        idle(22);
        run_job(2, 1, 1'b1);
        idle(6);

        // Abort mid-count, then everyone requests: aborted owner is skipped.
        run_job(0, 9, 1'b0);
        abort_at(3);
        idle(3);
        tick(1'b1, 4'b1111, $urandom, '0, 1'b0);
        idle(25);

        // Abort in the cycle the counter reads zero: no done pulse.
        run_job(3, 2, 1'b0);
        abort_at(0);
        idle(4);

        // Reset in the middle of a count, then all requesters held high.
        run_job(1, 10, 1'b0);
        for (int k = 0; k < 30; k++) begin
            if (m_job && (cyc + 1) > m_load_c && exp_cnt(cyc + 1) == 5) break;
            tick(1'b1, '0, '0, '0, 1'b0);
        end
        tick(1'b0, '0, '0, '0, 1'b0);
        tick(1'b0, 4'b1111, '0, '0, 1'b0);
        for (int k = 0; k < 80; k++) tick(1'b1, 4'b1111, $urandom, $urandom, 1'b0);

        // Randomized traffic with sticky requests and occasional aborts.
        rr = '0;
        for (int k = 0; k < 700; k++) begin
            rr = rr ^ N'($urandom & $urandom & $urandom);
            tick(1'b1, rr, $urandom, N'($urandom), ($urandom_range(0, 24) == 0));
        end
        idle(40);

        chk("scoreboard_drained", exp_q.size(), 0);
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
